// File: rtl/multicycle_control_fsm.sv
// Main control FSM for a multicycle RV32-subset core: sequences fetch, decode,
// memory access, ALU execute, writeback, branch and JAL steps, and traps on illegal opcodes.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       reg_write,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t state_q, state_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_IMM:            state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            // Loads and stores differ only in opcode[5]; the IR keeps it stable here.
            S_MEMADR: state_d = opcode[5] ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC_R: state_d = S_ALUWB;
            S_EXEC_I: state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JAL:    state_d = S_ALUWB;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore decode; FETCH alone gates its IR/PC writes on mem_ready. Reset forces idle outputs
    // so a stalled memory request is withdrawn in the same cycle rst rises.
    always_comb begin
        alu_op     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        trap       = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEMRD:  mem_req = 1'b1;
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                end
                S_EXEC_I: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b11;
                end
                S_ALUWB:  reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b01;
                    branch    = 1'b1;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                S_TRAP:   trap = 1'b1;
                default:  ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: directed instruction runs plus randomized instruction streams with
// random memory stalls, compared against a per-instruction state-trace and output-table model.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] res;
        logic       mem_req;
        logic       mem_we;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       reg_write;
        logic       trap;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic [1:0] alu_op, alu_src_a, alu_src_b, result_src;
    logic       mem_req, mem_we, ir_write, pc_write, branch, reg_write, trap;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_control_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .branch     (branch),
        .reg_write  (reg_write),
        .trap       (trap),
        .state      (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within its time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Control outputs each state must show, straight from the state descriptions.
    function automatic ctl_t model_out(input int st, input bit rdy);
        ctl_t c = '0;
        case (st)
            0:  begin c.mem_req = 1; c.src_b = 2'b10; c.res = 2'b10;
                      c.ir_write = rdy; c.pc_write = rdy; end
            1:  begin c.src_a = 2'b01; c.src_b = 2'b01; end
            2:  begin c.src_a = 2'b10; c.src_b = 2'b01; end
            3:  c.mem_req = 1;
            4:  begin c.res = 2'b01; c.reg_write = 1; end
            5:  begin c.mem_req = 1; c.mem_we = 1; end
            6:  begin c.src_a = 2'b10; c.alu_op = 2'b10; end
            7:  begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b11; end
            8:  c.reg_write = 1;
            9:  begin c.src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1; end
            10: begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_write = 1; end
            15: c.trap = 1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {OP_LOAD, OP_STORE, OP_R, OP_IMM, OP_BRANCH, OP_JAL};
    endfunction

    function automatic ctl_t observed();
        return {alu_op, alu_src_a, alu_src_b, result_src, mem_req, mem_we,
                ir_write, pc_write, branch, reg_write, trap};
    endfunction

    // One clock: drive mem_ready, check mid-cycle, then advance past the edge.
    task automatic step(input int exp_st, input bit rdy, input string tag);
        mem_ready = rdy;
        @(negedge clk);
        check({tag, "_state"}, 32'(state), 32'(exp_st));
        check({tag, "_ctl"}, 32'(observed()), 32'(model_out(exp_st, rdy)));
        check({tag, "_we_without_req"}, 32'(mem_we & ~mem_req), 32'd0);
        check({tag, "_rw_with_req"}, 32'(reg_write & mem_req), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int cycles, input string tag);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({tag, "_rst_ctl"}, 32'(observed()), 32'd0);
            if (i > 0) check({tag, "_rst_state"}, 32'(state), 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    // Instruction-level model: expected state trace derived from instruction class and stalls.
    task automatic run_instr(input logic [6:0] op, input int wf, input int wm, input string tag);
        int st_q[$];
        bit rdy_q[$];
        opcode = op;
        for (int i = 0; i < wf; i++) begin st_q.push_back(0); rdy_q.push_back(1'b0); end
        st_q.push_back(0); rdy_q.push_back(1'b1);
        st_q.push_back(1); rdy_q.push_back(1'($urandom_range(0, 1)));
        if (op == OP_LOAD || op == OP_STORE) begin
            int acc = (op == OP_LOAD) ? 3 : 5;
            st_q.push_back(2); rdy_q.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i < wm; i++) begin st_q.push_back(acc); rdy_q.push_back(1'b0); end
            st_q.push_back(acc); rdy_q.push_back(1'b1);
            if (op == OP_LOAD) begin st_q.push_back(4); rdy_q.push_back(1'($urandom_range(0, 1))); end
        end else if (op == OP_R || op == OP_IMM) begin
            st_q.push_back(op == OP_R ? 6 : 7); rdy_q.push_back(1'($urandom_range(0, 1)));
            st_q.push_back(8); rdy_q.push_back(1'($urandom_range(0, 1)));
        end else if (op == OP_BRANCH) begin
            st_q.push_back(9); rdy_q.push_back(1'($urandom_range(0, 1)));
        end else if (op == OP_JAL) begin
            st_q.push_back(10); rdy_q.push_back(1'($urandom_range(0, 1)));
            st_q.push_back(8); rdy_q.push_back(1'($urandom_range(0, 1)));
        end else begin
            for (int i = 0; i < 12; i++) begin st_q.push_back(15); rdy_q.push_back(1'($urandom_range(0, 1))); end
        end
        foreach (st_q[i]) step(st_q[i], rdy_q[i], tag);
    endtask

    initial begin
        logic [6:0] ops[6] = '{OP_LOAD, OP_STORE, OP_R, OP_IMM, OP_BRANCH, OP_JAL};
        rst = 1'b1;
        opcode = 7'd0;
        mem_ready = 1'b0;
        #1;
        apply_reset(3, "por");

        run_instr(OP_R,      0, 0, "r_type");
        run_instr(OP_LOAD,   0, 3, "load_wait3");
        run_instr(OP_STORE,  0, 0, "store");
        run_instr(OP_BRANCH, 0, 0, "branch");
        run_instr(OP_IMM,    0, 0, "op_imm");
        run_instr(OP_JAL,    0, 0, "jal");
        run_instr(OP_LOAD,   2, 0, "fetch_stall");

        run_instr(7'b0000000, 0, 0, "illegal");
        apply_reset(1, "trap_rst");
        run_instr(OP_R, 0, 0, "after_trap");

        // Reset while a store is stalled in MEMWR.
        opcode = OP_STORE;
        step(0, 1'b1, "midstall");
        step(1, 1'b0, "midstall");
        step(2, 1'b0, "midstall");
        step(5, 1'b0, "midstall");
        step(5, 1'b0, "midstall");
        mem_ready = 1'b0;
        apply_reset(2, "midstall");
        run_instr(OP_IMM, 0, 0, "after_midstall");

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                logic [6:0] bad;
                do bad = 7'($urandom); while (is_legal(bad));
                run_instr(bad, $urandom_range(0, 3), 0, "rand_illegal");
                apply_reset($urandom_range(1, 3), "rand_rst");
            end else begin
                run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3),
                          $urandom_range(0, 4), "rand");
            end
        end

        @(negedge clk);
        check("final_state", 32'(state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
